// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: access size
// encodings, FSM state type and byte-lane helper functions.
package riscv_mem_pkg;

    localparam int NBYTES = 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_t;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [NBYTES-1:0] strobe_mask(input logic [1:0] size);
        case (size)
            SZ_B:    strobe_mask = 8'h01;
            SZ_H:    strobe_mask = 8'h03;
            SZ_W:    strobe_mask = 8'h0F;
            default: strobe_mask = 8'hFF;
        endcase
    endfunction

    // Natural alignment: the low address bits below the access size must be zero.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = (offset[0] == 1'b0);
            SZ_W:    is_aligned = (offset[1:0] == 2'b00);
            default: is_aligned = (offset == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment: shifts store data and strobes onto the
// doubleword bus, and extracts/extends load fields from bus read data.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic [63:0] load_data
);

    logic [63:0] field;

    // Lane shift for stores; right-shift, truncate and extend for loads.
    always_comb begin
        wdata = store_data << {offset, 3'b000};
        wstrb = strobe_mask(size) << offset;
        field = rdata >> {offset, 3'b000};
        case (size)
            SZ_B:    load_data = is_unsigned ? {56'd0, field[7:0]}
                                             : {{56{field[7]}}, field[7:0]};
            SZ_H:    load_data = is_unsigned ? {48'd0, field[15:0]}
                                             : {{48{field[15]}}, field[15:0]};
            SZ_W:    load_data = is_unsigned ? {32'd0, field[31:0]}
                                             : {{32{field[31]}}, field[31:0]};
            default: load_data = field;  // LD, and func3=111 treated as LD
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Runs one data-memory transaction per
// load/store over a req/ready bus and stalls the pipeline until it completes.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            stall_m_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            load_valid_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_wstrb_o,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_ready_i
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_t      state;
    logic [63:0]     addr_reg;
    logic [2:0]      func3_reg;
    logic            we_reg;
    logic [63:0]     wdata_reg;
    logic [7:0]      wstrb_reg;
    logic [CW-1:0]   cnt;
    logic [63:0]     load_data_reg;
    logic            load_valid_reg;
    logic            misalign_reg;
    logic            bus_err_reg;

    logic            access;
    logic            is_store_in;
    logic            aligned_in;
    logic            timeout_hit;
    logic [2:0]      align_off;
    logic [2:0]      align_f3;
    logic [63:0]     align_wdata;
    logic [7:0]      align_wstrb;
    logic [63:0]     align_load;

    assign access      = mem_read_i | mem_write_i;
    assign is_store_in = mem_write_i & ~mem_read_i;  // load wins if both set
    assign aligned_in  = is_aligned(func3_i[1:0], addr_i[2:0]);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // In IDLE the aligner prepares store lanes from live inputs; afterwards
    // it extracts load data using the latched address/func3.
    assign align_off = (state == ST_IDLE) ? addr_i[2:0]  : addr_reg[2:0];
    assign align_f3  = (state == ST_IDLE) ? func3_i      : func3_reg;

    lsu_align u_align (
        .offset      (align_off),
        .size        (align_f3[1:0]),
        .is_unsigned (align_f3[2]),
        .store_data  (store_data_i),
        .rdata       (dmem_rdata_i),
        .wdata       (align_wdata),
        .wstrb       (align_wstrb),
        .load_data   (align_load)
    );

    // Transaction FSM with latched request fields and registered completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            addr_reg       <= '0;
            func3_reg      <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            cnt            <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        addr_reg  <= addr_i;
                        func3_reg <= func3_i;
                        we_reg    <= is_store_in;
                        wdata_reg <= is_store_in ? align_wdata : 64'd0;
                        wstrb_reg <= is_store_in ? align_wstrb : 8'h00;
                        if (aligned_in) begin
                            state <= ST_REQ;
                        end else begin
                            // No bus transfer; loads still complete (with zero data).
                            state          <= ST_DONE;
                            misalign_reg   <= 1'b1;
                            load_valid_reg <= ~is_store_in;
                            if (!is_store_in) load_data_reg <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_ready_i) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                        if (!we_reg) begin
                            load_valid_reg <= 1'b1;
                            load_data_reg  <= align_load;
                        end
                    end else if (timeout_hit) begin
                        state       <= ST_DONE;
                        cnt         <= '0;
                        bus_err_reg <= 1'b1;
                        if (!we_reg) begin
                            load_valid_reg <= 1'b1;
                            load_data_reg  <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign dmem_req_o   = (state == ST_REQ);
    assign stall_m_o    = ~reset & (((state == ST_IDLE) & access) | (state == ST_REQ));
    assign dmem_we_o    = we_reg;
    assign dmem_addr_o  = {addr_reg[63:3], 3'b000};
    assign dmem_wdata_o = wdata_reg;
    assign dmem_wstrb_o = wstrb_reg;
    assign load_data_o  = load_data_reg;
    assign load_valid_o = load_valid_reg;
    assign misalign_o   = misalign_reg;
    assign bus_err_o    = bus_err_reg;

endmodule
